// File: rtl/alu_sequencer.sv
// alu_sequencer: issue and writeback stage between fetch and the ALU.
//
// This module takes one 16-bit instruction from fetch over a valid/ready
// handshake. It drives the opcode and operands to the external
// combinational ALU. On the following edge it writes the ALU result back
// into a 4 x DATA_W register file and updates the flags register.
// Each instruction takes two cycles: an accept edge, then a writeback edge.
//
// Ports
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   instr_valid, instr    fetch handshake; instr = {op, rd, rs, imm}
//   instr_ready           high while idle and able to accept
//   alu_op, alu_x, alu_y  opcode and operands presented to the ALU
//   alu_out, alu_flags    ALU result (low DATA_W bits used), ALU flags
//   flags                 {0, neg, zero, carry} of the last legal op
//   done, illegal         one-cycle retire pulse; illegal marks ops C..F
//   dbg_sel, dbg_data     combinational register file read port
module alu_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [15:0]       alu_out,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags,
  output logic              done,
  output logic              illegal,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_SUM = 4'h0;
  localparam logic [3:0] OP_SMI = 4'h1;
  localparam logic [3:0] OP_SB  = 4'h2;
  localparam logic [3:0] OP_SBI = 4'h3;
  localparam logic [3:0] OP_CM  = 4'h4;
  localparam logic [3:0] OP_CMI = 4'h5;
  localparam logic [3:0] OP_ANR = 4'h6;
  localparam logic [3:0] OP_ANI = 4'h7;
  localparam logic [3:0] OP_ORR = 4'h8;
  localparam logic [3:0] OP_ORI = 4'h9;
  localparam logic [3:0] OP_XRR = 4'hA;
  localparam logic [3:0] OP_XRI = 4'hB;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state;
  logic [15:0]       instr_p0;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [3:0]        op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [DATA_W-1:0] imm;
  logic              wb_zero;
  logic              unused_bits;

  // Opcodes C..F have no defined operation.
  function automatic logic is_legal(input logic [3:0] opc);
    return (opc < 4'hC);
  endfunction

  assign op  = instr_p0[15:12];
  assign rd  = instr_p0[11:10];
  assign rs  = instr_p0[9:8];
  assign imm = instr_p0[DATA_W-1:0];

  assign instr_ready = (state == IDLE);
  assign alu_op      = op;
  assign dbg_data    = regs[dbg_sel];

  // The ALU sets only carry (bit0) and neg (bit2) meaningfully.
  // Zero is therefore derived here from the written-back byte.
  assign wb_zero     = (alu_out[DATA_W-1:0] == '0);
  assign unused_bits = &{1'b0, alu_out[15:DATA_W], alu_flags[3], alu_flags[1]};

  // Operands come from the latched instruction and the live register file.
  // When rd == rs, the ALU therefore sees the value before this cycle's write.
  always_comb begin
    alu_x = '0;
    alu_y = '0;
    case (op)
      OP_SUM, OP_SB, OP_ANR, OP_ORR, OP_XRR: begin
        alu_x = regs[rd];
        alu_y = regs[rs];
      end
      OP_SMI, OP_SBI, OP_ANI, OP_ORI, OP_XRI: begin
        alu_x = regs[rd];
        alu_y = imm;
      end
      OP_CM:   alu_x = regs[rs];
      OP_CMI:  alu_x = imm;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      instr_p0 <= '0;
      flags    <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        // Accept stage: capture the instruction on the handshake.
        IDLE: begin
          if (instr_valid) begin
            instr_p0 <= instr;
            state    <= EXEC;
          end
        end
        // Writeback stage: the ALU result is settled; retire the instruction.
        EXEC: begin
          if (is_legal(op)) begin
            regs[rd] <= alu_out[DATA_W-1:0];
            flags    <= {1'b0, alu_flags[2], wb_zero, alu_flags[0]};
          end
          done    <= 1'b1;
          illegal <= ~is_legal(op);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. A small combinational ALU stand-in answers the
// DUT's requests. Stimulus pushes hand-computed expected results into a
// queue, and a monitor pops and compares one entry on each done pulse.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_op;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic        done;
  logic        illegal;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  logic        stim_ovr;
  logic [1:0]  stim_sel;
  logic [1:0]  mon_sel;
  assign dbg_sel = stim_ovr ? stim_sel : mon_sel;

  alu_sequencer #(.NUM_REGS(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_flags(alu_flags), .flags(flags), .done(done),
    .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ALU stand-in. Flag bits 1 and 3 and the upper result byte are junk,
  // because the sequencer must ignore them. Illegal ops return a non-zero
  // result with carry set, so any stray writeback shows up.
  logic [8:0] w;
  always_comb begin
    w = 9'h000;
    case (alu_op)
      4'h0, 4'h1: w = {1'b0, alu_x} + {1'b0, alu_y};
      4'h2, 4'h3: w = {1'b0, alu_x} - {1'b0, alu_y};
      4'h4, 4'h5: w = {1'b0, ~alu_x};
      4'h6, 4'h7: w = {1'b0, alu_x & alu_y};
      4'h8, 4'h9: w = {1'b0, alu_x | alu_y};
      4'hA, 4'hB: w = {1'b0, alu_x ^ alu_y};
      default:    w = 9'h1FF;
    endcase
    alu_out   = {8'hA5, w[7:0]};
    alu_flags = {1'b1, w[7], 1'b1, w[8]};
  end

  typedef struct {
    logic [1:0] rd;
    logic [7:0] val;
    logic [3:0] flg;
    logic       ill;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rdreg(input logic [1:0] idx, input logic [7:0] exp, input string name);
    stim_ovr = 1'b1;
    stim_sel = idx;
    #1;
    chk(name, 16'(dbg_data), 16'(exp));
    stim_ovr = 1'b0;
  endtask

  // Present one instruction, wait for the accept edge, then queue its expected result.
  task automatic issue(input logic [15:0] wd, input logic [1:0] crd, input logic [7:0] val,
                       input logic [3:0] flg, input logic ill);
    exp_t e;
    int   n;
    @(negedge clock);
    instr_valid = 1'b1;
    instr       = wd;
    n           = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) begin
      chk("accept_timeout", 16'(instr_ready), 16'd1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    e.rd = crd; e.val = val; e.flg = flg; e.ill = ill; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("drain", 16'(sb.size()), 16'd0);
    @(negedge clock);
  endtask

  // Monitor: compare each retired instruction against the scoreboard head.
  initial begin
    exp_t e;
    mon_sel = 2'd0;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 16'(done), 16'd0);
        end else begin
          e       = sb.pop_front();
          mon_sel = e.rd;
          #1;
          chk("wb_reg",   16'(dbg_data), 16'(e.val));
          chk("wb_flags", 16'(flags),    16'(e.flg));
          chk("illegal",  16'(illegal),  16'(e.ill));
          chk("done_lat", 16'(cyc),      16'(e.acc + 1));
        end
      end else if (illegal !== 1'b0) begin
        chk("illegal_without_done", 16'(illegal), 16'd0);
      end
    end
  end

  initial begin
    exp_t       e;
    logic [7:0] tog_exp [3];
    int         k;

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    stim_ovr    = 1'b0;
    stim_sel    = 2'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state, then ten idle cycles.
    chk("rst_ready",   16'(instr_ready), 16'd1);
    chk("rst_done",    16'(done),        16'd0);
    chk("rst_illegal", 16'(illegal),     16'd0);
    chk("rst_flags",   16'(flags),       16'h0);
    chk("rst_alu_op",  16'(alu_op),      16'h0);
    for (int i = 0; i < 4; i++) rdreg(2'(i), 8'h00, "rst_reg");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_done",  16'(done),        16'd0);
      chk("idle_ready", 16'(instr_ready), 16'd1);
    end

    // ORI R0,0x7F ; SMI R0,0x01
    issue(16'h907F, 2'd0, 8'h7F, 4'h0, 1'b0);
    issue(16'h1001, 2'd0, 8'h80, 4'h4, 1'b0);
    // ORI R1,0xFF ; SMI R1,0x01 -> wraps with carry and zero
    issue(16'h94FF, 2'd1, 8'hFF, 4'h4, 1'b0);
    issue(16'h1401, 2'd1, 8'h00, 4'h3, 1'b0);
    // ORI R2,0x05 ; SB R2,R2 ; CMI R3,0x0F
    issue(16'h9805, 2'd2, 8'h05, 4'h0, 1'b0);
    issue(16'h2A00, 2'd2, 8'h00, 4'h2, 1'b0);
    issue(16'h5C0F, 2'd3, 8'hF0, 4'h4, 1'b0);
    // ORI R1,0x55 ; ORI R2,0x80 (flags=0x4) ; illegal 0xE123
    issue(16'h9455, 2'd1, 8'h55, 4'h0, 1'b0);
    issue(16'h9880, 2'd2, 8'h80, 4'h4, 1'b0);
    issue(16'hE123, 2'd1, 8'h55, 4'h4, 1'b1);
    wait_drain();
    rdreg(2'd0, 8'h80, "r0_after_illegal");
    rdreg(2'd1, 8'h55, "r1_after_illegal");
    chk("flags_after_illegal", 16'(flags), 16'h4);

    // Hold SMI R3,0x01 valid: ready toggles and one accept happens per two cycles.
    tog_exp[0] = 8'hF1; tog_exp[1] = 8'hF2; tog_exp[2] = 8'hF3;
    k = 0;
    @(negedge clock);
    instr_valid = 1'b1;
    instr       = 16'h1D01;
    for (int i = 0; i < 6; i++) begin
      chk("ready_toggle", 16'(instr_ready), 16'((i % 2) == 0));
      if (instr_ready === 1'b1 && k < 3) begin
        e.rd = 2'd3; e.val = tog_exp[k]; e.flg = 4'h4; e.ill = 1'b0; e.acc = cyc + 1;
        sb.push_back(e);
        k++;
      end
      @(negedge clock);
    end
    instr_valid = 1'b0;
    wait_drain();
    chk("toggle_accepts", 16'(k), 16'd3);

    // Reset during EXEC aborts ORI R0,0xAA with no write and no done.
    @(negedge clock);
    chk("pre_abort_ready", 16'(instr_ready), 16'd1);
    instr_valid = 1'b1;
    instr       = 16'h90AA;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    chk("abort_in_exec", 16'(instr_ready), 16'd0);
    reset = 1'b1;
    #1;
    chk("abort_ready_async", 16'(instr_ready), 16'd1);
    rdreg(2'd0, 8'h00, "abort_r0");
    rdreg(2'd3, 8'h00, "abort_r3");
    chk("abort_flags", 16'(flags), 16'h0);
    @(negedge clock);
    chk("abort_done", 16'(done), 16'd0);
    @(negedge clock);
    reset = 1'b0;

    // The first edge with reset low accepts ORI R0,0x33.
    instr_valid = 1'b1;
    instr       = 16'h9033;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    e.rd = 2'd0; e.val = 8'h33; e.flg = 4'h0; e.ill = 1'b0; e.acc = cyc;
    sb.push_back(e);
    chk("first_accept", 16'(instr_ready), 16'd0);
    wait_drain();
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
